// File: rtl/br_pkg.sv
// Shared encodings for the ID-stage branch resolution controller:
// branch opcodes, FSM states and the stall counter limit.
package br_pkg;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLEZ = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Invalid opcodes need no operands, so they resolve immediately.
  function automatic logic op_needs_rs(input logic [2:0] op);
    return (op <= BR_BGEZ);
  endfunction

  function automatic logic op_needs_rt(input logic [2:0] op);
    return (op == BR_BEQ) || (op == BR_BNE);
  endfunction

endpackage

// File: rtl/br_cond.sv
// Combinational branch condition and target evaluation.
// Target wraps modulo 2^32; invalid opcodes are never taken.
module br_cond
  import br_pkg::*;
(
  input  logic [2:0]  br_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  output logic        taken,
  output logic [31:0] target
);

  logic rs_zero;
  logic rs_neg;

  assign rs_zero = (rs == 32'd0);
  assign rs_neg  = rs[31];

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_BEQ:  taken = (rs == rt);
      BR_BNE:  taken = (rs != rt);
      BR_BLEZ: taken = rs_neg | rs_zero;
      BR_BGTZ: taken = !rs_neg & !rs_zero;
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = !rs_neg;
      default: taken = 1'b0;
    endcase
  end

  assign target = pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: waits for forwarded operands, latches the
// taken/target pair, stalls IF/ID meanwhile and counts operand-wait cycles.
//
// state  | meaning
// S_IDLE | no branch in flight; a ready branch resolves this cycle
// S_WAIT | branch in ID, at least one required operand still pending
// S_DONE | result latched, br_done high; branch leaves ID this cycle
module branch_ctrl
  import br_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  input  logic [2:0]  br_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic [31:0] pc_id,
  input  logic [15:0] imm16,
  input  logic        stall_clr,
  output logic        stall,
  output logic        br_done,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic [15:0] stall_cnt
);

  state_t      state;
  logic        ready;
  logic        latch_now;
  logic        wait_inc;
  logic        c_taken;
  logic [31:0] c_target;

  br_cond u_cond (
    .br_op  (br_op),
    .rs     (rs_val),
    .rt     (rt_val),
    .pc     (pc_id),
    .imm16  (imm16),
    .taken  (c_taken),
    .target (c_target)
  );

  assign ready     = (!op_needs_rs(br_op) | rs_ready) & (!op_needs_rt(br_op) | rt_ready);
  assign latch_now = br_valid & ready & (state != S_DONE);
  // Every cycle the branch is held in ID for lack of an operand.
  assign wait_inc  = br_valid & !ready & (state != S_DONE);
  assign stall     = br_valid & (state != S_DONE) & !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      br_done   <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= 32'd0;
    end else begin
      br_done <= 1'b0;
      if (latch_now) begin
        br_taken  <= c_taken;
        br_target <= c_target;
      end
      case (state)
        S_IDLE: begin
          if (br_valid) begin
            if (ready) begin
              state   <= S_DONE;
              br_done <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!br_valid) begin
            state <= S_IDLE;
          end else if (ready) begin
            state   <= S_DONE;
            br_done <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (stall_clr) begin
      stall_cnt <= 16'd0;
    end else if (wait_inc && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
